// File: rtl/tdc_stats_pkg.sv
// tdc_stats_pkg: shared widths, initial values and state type for the TDC result
// statistics block.
//   SUM_W / SQ_W   : accumulator widths for the default configuration.
//   sum_w / sq_w   : the same widths computed for any DATA_WIDTH / WINDOW_LOG2.
//   MIN_INIT       : minimum accumulator start value (all-ones).
//   MAX_INIT       : maximum accumulator start value (zero).
//   res_state_e    : result register occupancy.
package tdc_stats_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 32;
  localparam int unsigned WINDOW_LOG2_DEF = 8;
  localparam int unsigned ERR_WIDTH_DEF   = 16;

  // The sum of 2^WINDOW_LOG2 samples needs WINDOW_LOG2 extra bits and cannot overflow.
  localparam int unsigned SUM_W = DATA_WIDTH_DEF + WINDOW_LOG2_DEF;
  localparam int unsigned SQ_W  = 2 * DATA_WIDTH_DEF + WINDOW_LOG2_DEF;

  localparam logic [DATA_WIDTH_DEF-1:0] MIN_INIT = '1;
  localparam logic [DATA_WIDTH_DEF-1:0] MAX_INIT = '0;

  typedef enum logic {
    RES_EMPTY,
    RES_FULL
  } res_state_e;

  function automatic int unsigned sum_w(input int unsigned dw, input int unsigned wl);
    return dw + wl;
  endfunction

  function automatic int unsigned sq_w(input int unsigned dw, input int unsigned wl);
    return 2 * dw + wl;
  endfunction

endpackage

// File: rtl/tdc_result_stats_if.sv
// tdc_result_stats_if: sample stream in, window result out.
//   master : producer/consumer side (drives samples, clear and out_ready).
//   slave  : the statistics block (drives the result, overrun and fill).
interface tdc_result_stats_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned ERR_WIDTH   = 16
);

  logic                              in_valid;
  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_error;
  logic                              clear;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH-1:0]             out_min;
  logic [DATA_WIDTH-1:0]             out_max;
  logic [DATA_WIDTH-1:0]             out_mean;
  logic [ERR_WIDTH-1:0]              out_errors;
  logic [2*DATA_WIDTH+WINDOW_LOG2-1:0] out_sumsq;
  logic                              overrun;
  logic [WINDOW_LOG2:0]              fill;

  modport master (
    output in_valid, in_data, in_error, clear, out_ready,
    input  out_valid, out_min, out_max, out_mean, out_errors, out_sumsq, overrun, fill
  );

  modport slave (
    input  in_valid, in_data, in_error, clear, out_ready,
    output out_valid, out_min, out_max, out_mean, out_errors, out_sumsq, overrun, fill
  );

endinterface

// File: rtl/tdc_stats_datapath.sv
// tdc_stats_datapath: running min/max/sum (and optional sum of squares) for one window.
//   clk, rst   : clock, asynchronous active-high reset.
//   acc_en     : fold the current sample into the accumulators.
//   init       : return accumulators to their initial values (wins over acc_en).
//   data / sq  : sample and its square (sq only with TDC_STATS_SUMSQ_EN).
//   *_nx       : accumulator values including the current sample, used to load results.
// Macro TDC_STATS_SUMSQ_EN adds the sum-of-squares accumulator.
module tdc_stats_datapath
  import tdc_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WINDOW_LOG2 = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               acc_en,
  input  logic                               init,
  input  logic [DATA_WIDTH-1:0]              data,
`ifdef TDC_STATS_SUMSQ_EN
  input  logic [2*DATA_WIDTH-1:0]            sq,
  output logic [2*DATA_WIDTH+WINDOW_LOG2-1:0] sumsq_nx,
`endif
  output logic [DATA_WIDTH-1:0]              min_nx,
  output logic [DATA_WIDTH-1:0]              max_nx,
  output logic [DATA_WIDTH+WINDOW_LOG2-1:0]  sum_nx
);

  localparam int unsigned SumW = sum_w(DATA_WIDTH, WINDOW_LOG2);

  logic [DATA_WIDTH-1:0] min_q;
  logic [DATA_WIDTH-1:0] max_q;
  logic [SumW-1:0]       sum_q;

  always_comb begin
    min_nx = (data < min_q) ? data : min_q;
    max_nx = (data > max_q) ? data : max_q;
    sum_nx = sum_q + SumW'(data);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (init) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (acc_en) begin
      min_q <= min_nx;
      max_q <= max_nx;
      sum_q <= sum_nx;
    end
  end

`ifdef TDC_STATS_SUMSQ_EN
  localparam int unsigned SqW = sq_w(DATA_WIDTH, WINDOW_LOG2);

  logic [SqW-1:0] sumsq_q;

  assign sumsq_nx = sumsq_q + SqW'(sq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sumsq_q <= '0;
    end else if (init) begin
      sumsq_q <= '0;
    end else if (acc_en) begin
      sumsq_q <= sumsq_nx;
    end
  end
`endif

endmodule

// File: rtl/tdc_result_stats.sv
// tdc_result_stats: windowed min/max/mean/error statistics over the TDC result stream.
//   clk, rst : TDC system clock, asynchronous active-high reset.
//   bus      : slave side of tdc_result_stats_if (samples, clear, result handshake,
//              sticky overrun, current window fill).
// Macro TDC_STATS_SUMSQ_EN: registers the sample and its square one stage ahead of the
// accumulators (result latency 2) and reports the window sum of squares; otherwise
// out_sumsq is tied to 0 and latency is 1.
module tdc_result_stats
  import tdc_stats_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned ERR_WIDTH   = 16
) (
  input logic              clk,
  input logic              rst,
  tdc_result_stats_if.slave bus
);

  localparam int unsigned SumW = sum_w(DATA_WIDTH, WINDOW_LOG2);
  localparam int unsigned CntW = WINDOW_LOG2 + 1;
  localparam logic [CntW-1:0] LastCnt = {1'b0, {WINDOW_LOG2{1'b1}}};

  // Strobe as seen by the accumulators (possibly one stage late).
  logic                  s_valid;
  logic                  s_error;
  logic [DATA_WIDTH-1:0] s_data;

`ifdef TDC_STATS_SUMSQ_EN
  localparam int unsigned SqW = sq_w(DATA_WIDTH, WINDOW_LOG2);

  logic                    p_valid_q;
  logic                    p_error_q;
  logic [DATA_WIDTH-1:0]   p_data_q;
  logic [2*DATA_WIDTH-1:0] p_sq_q;
  logic [SqW-1:0]          sumsq_nx;
  logic [SqW-1:0]          out_sumsq_q;

  // Clear both drops the incoming strobe and kills the one already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_valid_q <= 1'b0;
      p_error_q <= 1'b0;
      p_data_q  <= '0;
      p_sq_q    <= '0;
    end else begin
      p_valid_q <= bus.in_valid & ~bus.clear;
      p_error_q <= bus.in_error;
      p_data_q  <= bus.in_data;
      p_sq_q    <= {{DATA_WIDTH{1'b0}}, bus.in_data} * {{DATA_WIDTH{1'b0}}, bus.in_data};
    end
  end

  assign s_valid = p_valid_q;
  assign s_error = p_error_q;
  assign s_data  = p_data_q;
`else
  assign s_valid = bus.in_valid;
  assign s_error = bus.in_error;
  assign s_data  = bus.in_data;
`endif

  logic accept;
  logic err_strobe;
  logic done;

  logic [CntW-1:0]       count_q;
  logic [ERR_WIDTH-1:0]  err_q;
  res_state_e            res_state_q;
  logic                  out_valid_q;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] out_min_q;
  logic [DATA_WIDTH-1:0] out_max_q;
  logic [DATA_WIDTH-1:0] out_mean_q;
  logic [ERR_WIDTH-1:0]  out_errors_q;

  logic [DATA_WIDTH-1:0] min_nx;
  logic [DATA_WIDTH-1:0] max_nx;
  logic [SumW-1:0]       sum_nx;

  assign accept     = s_valid & ~s_error & ~bus.clear;
  assign err_strobe = s_valid & s_error & ~bus.clear;
  assign done       = accept & (count_q == LastCnt);

  tdc_stats_datapath #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_datapath (
    .clk      (clk),
    .rst      (rst),
    .acc_en   (accept),
    .init     (bus.clear | done),
    .data     (s_data),
`ifdef TDC_STATS_SUMSQ_EN
    .sq       (p_sq_q),
    .sumsq_nx (sumsq_nx),
`endif
    .min_nx   (min_nx),
    .max_nx   (max_nx),
    .sum_nx   (sum_nx)
  );

  // Window counter and saturating error counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      err_q   <= '0;
    end else if (bus.clear || done) begin
      count_q <= '0;
      err_q   <= '0;
    end else begin
      if (accept) count_q <= count_q + CntW'(1);
      if (err_strobe && (err_q != '1)) err_q <= err_q + ERR_WIDTH'(1);
    end
  end

  // Result register: a completion always loads, even over an unconsumed result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_state_q  <= RES_EMPTY;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      out_min_q    <= '0;
      out_max_q    <= '0;
      out_mean_q   <= '0;
      out_errors_q <= '0;
`ifdef TDC_STATS_SUMSQ_EN
      out_sumsq_q  <= '0;
`endif
    end else begin
      unique case (res_state_q)
        RES_EMPTY: begin
          if (done) begin
            res_state_q <= RES_FULL;
            out_valid_q <= 1'b1;
          end
        end
        RES_FULL: begin
          if (done) begin
            // Handshake on the same edge consumes the old result: not an overrun.
            if (!bus.out_ready) overrun_q <= 1'b1;
          end else if (bus.out_ready) begin
            res_state_q <= RES_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
      endcase
      if (done) begin
        out_min_q    <= min_nx;
        out_max_q    <= max_nx;
        out_mean_q   <= DATA_WIDTH'(sum_nx >> WINDOW_LOG2);
        out_errors_q <= err_q;
`ifdef TDC_STATS_SUMSQ_EN
        out_sumsq_q  <= sumsq_nx;
`endif
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_min    = out_min_q;
  assign bus.out_max    = out_max_q;
  assign bus.out_mean   = out_mean_q;
  assign bus.out_errors = out_errors_q;
  assign bus.overrun    = overrun_q;
  assign bus.fill       = count_q;
`ifdef TDC_STATS_SUMSQ_EN
  assign bus.out_sumsq  = out_sumsq_q;
`else
  assign bus.out_sumsq  = '0;
`endif

endmodule

// File: tb/tb_tdc_result_stats.sv
// tb_tdc_result_stats: directed bench for tdc_result_stats with a 4-sample window.
// Works with or without TDC_STATS_SUMSQ_EN (result latency 2 vs 1).
module tb_tdc_result_stats;

  localparam int unsigned DW = 32;
  localparam int unsigned WL = 2;
  localparam int unsigned EW = 16;

`ifdef TDC_STATS_SUMSQ_EN
  localparam logic [127:0] SumsqExp = 128'd25;
`else
  localparam logic [127:0] SumsqExp = 128'd0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tdc_result_stats_if #(
    .DATA_WIDTH  (DW),
    .WINDOW_LOG2 (WL),
    .ERR_WIDTH   (EW)
  ) bus ();

  tdc_result_stats #(
    .DATA_WIDTH  (DW),
    .WINDOW_LOG2 (WL),
    .ERR_WIDTH   (EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic err, input logic [DW-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_error = err;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_error = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send4(input logic [DW-1:0] d);
    for (int i = 0; i < 4; i++) send(1'b0, d);
  endtask

  // Extra cycle for the registered square stage.
  task automatic drain();
`ifdef TDC_STATS_SUMSQ_EN
    tick();
`endif
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [DW-1:0] mn, input logic [DW-1:0] mx,
                         input logic [DW-1:0] mean, input logic [EW-1:0] errs);
    chk({tag, "_valid"}, 128'(bus.out_valid), 128'd1);
    chk({tag, "_min"}, 128'(bus.out_min), 128'(mn));
    chk({tag, "_max"}, 128'(bus.out_max), 128'(mx));
    chk({tag, "_mean"}, 128'(bus.out_mean), 128'(mean));
    chk({tag, "_errors"}, 128'(bus.out_errors), 128'(errs));
    chk({tag, "_fill"}, 128'(bus.fill), 128'd0);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_error = 1'b0;
    bus.in_data  = '0;
    bus.clear    = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values.
    #23;
    chk("rst_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_min", 128'(bus.out_min), 128'd0);
    chk("rst_mean", 128'(bus.out_mean), 128'd0);
    chk("rst_overrun", 128'(bus.overrun), 128'd0);
    chk("rst_fill", 128'(bus.fill), 128'd0);
    rst = 1'b0;
    tick();

    // Basic window, consumed immediately.
    send(1'b0, 100);
    send(1'b0, 300);
    send(1'b0, 200);
    send(1'b0, 400);
    drain();
    chk_res("w1", 100, 400, 250, 0);
    tick();
    chk("w1_consumed", 128'(bus.out_valid), 128'd0);

    // Error strobes interleaved; their data must not reach min.
    send(1'b0, 10);
    send(1'b1, 1);
    send(1'b0, 20);
    drain();
    chk("w2_fill_mid", 128'(bus.fill), 128'd2);
    send(1'b1, 1);
    send(1'b1, 1);
    send(1'b0, 30);
    send(1'b0, 41);
    drain();
    chk_res("w2", 10, 41, 25, 3);
    tick();
    chk("w2_consumed", 128'(bus.out_valid), 128'd0);

    // Completion on the same edge as the handshake: reload, no overrun.
    bus.out_ready = 1'b0;
    send4(2);
    drain();
    chk_res("w3", 2, 2, 2, 0);
    send(1'b0, 8);
    send(1'b0, 8);
    send(1'b0, 8);
`ifdef TDC_STATS_SUMSQ_EN
    send(1'b0, 8);
    bus.out_ready = 1'b1;
    tick();
`else
    bus.out_ready = 1'b1;
    send(1'b0, 8);
`endif
    bus.out_ready = 1'b0;
    chk_res("w4", 8, 8, 8, 0);
    chk("w4_overrun", 128'(bus.overrun), 128'd0);
    bus.out_ready = 1'b1;
    tick();
    chk("w4_consumed", 128'(bus.out_valid), 128'd0);

    // Overrun: two windows with the consumer stalled.
    bus.out_ready = 1'b0;
    send4(1);
    drain();
    chk_res("w5", 1, 1, 1, 0);
    chk("w5_overrun", 128'(bus.overrun), 128'd0);
    send4(5);
    drain();
    chk_res("w6", 5, 5, 5, 0);
    chk("w6_overrun", 128'(bus.overrun), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("w6_consumed", 128'(bus.out_valid), 128'd0);
    chk("w6_overrun_sticky", 128'(bus.overrun), 128'd1);

    // Clear mid-window with a simultaneous strobe that must be dropped.
    send(1'b0, 50);
    send(1'b0, 60);
    bus.clear = 1'b1;
    send(1'b0, 999);
    bus.clear = 1'b0;
    chk("clr_fill", 128'(bus.fill), 128'd0);
    send4(7);
    drain();
    chk_res("w7", 7, 7, 7, 0);
    chk("w7_overrun_kept", 128'(bus.overrun), 128'd1);
    tick();
    chk("w7_consumed", 128'(bus.out_valid), 128'd0);

    // Sum of squares, then left pending for the reset check.
    bus.out_ready = 1'b0;
    send(1'b0, 3);
    send(1'b0, 4);
    send(1'b0, 0);
    send(1'b0, 0);
    drain();
    chk_res("w8", 0, 4, 1, 0);
    chk("w8_sumsq", 128'(bus.out_sumsq), SumsqExp);

    // Asynchronous reset mid-window, away from the clock edge.
    send(1'b0, 9);
    send(1'b0, 9);
    drain();
    chk("pre_rst_fill", 128'(bus.fill), 128'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 128'(bus.out_valid), 128'd0);
    chk("arst_min", 128'(bus.out_min), 128'd0);
    chk("arst_max", 128'(bus.out_max), 128'd0);
    chk("arst_mean", 128'(bus.out_mean), 128'd0);
    chk("arst_sumsq", 128'(bus.out_sumsq), 128'd0);
    chk("arst_overrun", 128'(bus.overrun), 128'd0);
    chk("arst_fill", 128'(bus.fill), 128'd0);
    #2 rst = 1'b0;
    tick();

    // Partial 9s must be gone after reset.
    bus.out_ready = 1'b1;
    send4(6);
    drain();
    chk_res("w9", 6, 6, 6, 0);
    chk("w9_overrun", 128'(bus.overrun), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
